// File: rtl/config_int_add_apx_ctrl.sv
// Closed-loop approximation controller for the input-truncation adder: measures the exact
// truncation error per window and toggles apx_ctl through a hysteretic FSM at window close.
module config_int_add_apx_ctrl #(
    parameter int unsigned DATA_PATH_BITWIDTH = 32,
    parameter int unsigned HRDWIRED_BITWIDTH  = 4,
    parameter int unsigned WINDOW             = 16,
    parameter int unsigned ERR_ACC_BITWIDTH   = 16,
    parameter int unsigned HOLD_WINDOWS       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          force_acc,
    input  logic                          in_valid,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic [ERR_ACC_BITWIDTH-1:0]   err_thresh_hi,
    input  logic [ERR_ACC_BITWIDTH-1:0]   err_thresh_lo,
    output logic                          apx_ctl,
    output logic                          win_done,
    output logic [ERR_ACC_BITWIDTH-1:0]   win_err,
    output logic [1:0]                    state
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StApx     = 2'd1;
    localparam logic [1:0] StAcc     = 2'd2;
    localparam logic [1:0] StRecover = 2'd3;

    localparam int unsigned EW = HRDWIRED_BITWIDTH + 1;
    localparam int unsigned SW = ERR_ACC_BITWIDTH + EW;
    localparam int unsigned CW = $clog2(WINDOW);
    localparam int unsigned GW = $clog2(HOLD_WINDOWS + 1);

    localparam logic [CW-1:0] OpLast   = CW'(WINDOW - 1);
    localparam logic [GW-1:0] GoodLast = GW'(HOLD_WINDOWS - 1);
    localparam logic [SW-1:0] AccMax   = SW'({ERR_ACC_BITWIDTH{1'b1}});

    logic [1:0]                  state_q, state_d;
    logic                        apx_ctl_q, apx_ctl_d;
    logic                        win_done_q, win_done_d;
    logic [ERR_ACC_BITWIDTH-1:0] win_err_q, win_err_d;
    logic [ERR_ACC_BITWIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]               op_cnt_q, op_cnt_d;
    logic [GW-1:0]               good_cnt_q, good_cnt_d;

    logic [EW-1:0]               err_op;
    logic [SW-1:0]               sum_wide;
    logic [ERR_ACC_BITWIDTH-1:0] sat_sum;
    logic                        unused_hi_bits;

    // Only the truncated low bits contribute to the error.
    assign unused_hi_bits = ^{a[DATA_PATH_BITWIDTH-1:HRDWIRED_BITWIDTH],
                              b[DATA_PATH_BITWIDTH-1:HRDWIRED_BITWIDTH]};

    assign err_op   = EW'(a[HRDWIRED_BITWIDTH-1:0]) + EW'(b[HRDWIRED_BITWIDTH-1:0]);
    assign sum_wide = SW'(acc_q) + SW'(err_op);
    assign sat_sum  = (sum_wide > AccMax) ? {ERR_ACC_BITWIDTH{1'b1}}
                                          : sum_wide[ERR_ACC_BITWIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        win_done_d = 1'b0;
        win_err_d  = win_err_q;
        acc_d      = acc_q;
        op_cnt_d   = op_cnt_q;
        good_cnt_d = good_cnt_q;

        if (state_q == StIdle) begin
            acc_d      = '0;
            op_cnt_d   = '0;
            good_cnt_d = '0;
            if (en) state_d = StApx;
        end else begin
            if (in_valid) begin
                if (op_cnt_q == OpLast) begin
                    win_done_d = 1'b1;
                    win_err_d  = sat_sum;
                    acc_d      = '0;
                    op_cnt_d   = '0;
                    case (state_q)
                        StApx: begin
                            if (sat_sum > err_thresh_hi) state_d = StAcc;
                        end
                        StAcc: begin
                            if (sat_sum <= err_thresh_lo) begin
                                if (HOLD_WINDOWS == 1) begin
                                    state_d = StApx;
                                end else begin
                                    state_d    = StRecover;
                                    good_cnt_d = GW'(1);
                                end
                            end
                        end
                        StRecover: begin
                            if (sat_sum <= err_thresh_lo) begin
                                if (good_cnt_q == GoodLast) begin
                                    state_d    = StApx;
                                    good_cnt_d = '0;
                                end else begin
                                    good_cnt_d = good_cnt_q + GW'(1);
                                end
                            end else begin
                                state_d    = StAcc;
                                good_cnt_d = '0;
                            end
                        end
                        default: state_d = state_q;
                    endcase
                end else begin
                    acc_d    = sat_sum;
                    op_cnt_d = op_cnt_q + CW'(1);
                end
            end
            // Disable overrides any transition but keeps the window report.
            if (!en) begin
                state_d    = StIdle;
                acc_d      = '0;
                op_cnt_d   = '0;
                good_cnt_d = '0;
            end
        end

        apx_ctl_d = (state_d == StApx) & ~force_acc & en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            apx_ctl_q  <= 1'b0;
            win_done_q <= 1'b0;
            win_err_q  <= '0;
            acc_q      <= '0;
            op_cnt_q   <= '0;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            apx_ctl_q  <= apx_ctl_d;
            win_done_q <= win_done_d;
            win_err_q  <= win_err_d;
            acc_q      <= acc_d;
            op_cnt_q   <= op_cnt_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    assign apx_ctl  = apx_ctl_q;
    assign win_done = win_done_q;
    assign win_err  = win_err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_config_int_add_apx_ctrl.sv
// Directed bench for config_int_add_apx_ctrl: a WINDOW=4 instance for the control flow and
// a narrow-accumulator WINDOW=16 instance for saturation.
module tb_config_int_add_apx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, force_acc, in_valid;
    logic [31:0] a, b;
    logic [15:0] thr_hi, thr_lo;
    logic        apx_ctl, win_done;
    logic [15:0] win_err;
    logic [1:0]  state;

    logic        en2, in_valid2;
    logic [31:0] a2, b2;
    logic [7:0]  thr_hi2, thr_lo2;
    logic        apx_ctl2, win_done2;
    logic [7:0]  win_err2;
    logic [1:0]  state2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    config_int_add_apx_ctrl #(
        .DATA_PATH_BITWIDTH(32), .HRDWIRED_BITWIDTH(4), .WINDOW(4),
        .ERR_ACC_BITWIDTH(16), .HOLD_WINDOWS(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .force_acc(force_acc), .in_valid(in_valid),
        .a(a), .b(b), .err_thresh_hi(thr_hi), .err_thresh_lo(thr_lo),
        .apx_ctl(apx_ctl), .win_done(win_done), .win_err(win_err), .state(state)
    );

    config_int_add_apx_ctrl #(
        .DATA_PATH_BITWIDTH(32), .HRDWIRED_BITWIDTH(4), .WINDOW(16),
        .ERR_ACC_BITWIDTH(8), .HOLD_WINDOWS(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .en(en2), .force_acc(1'b0), .in_valid(in_valid2),
        .a(a2), .b(b2), .err_thresh_hi(thr_hi2), .err_thresh_lo(thr_lo2),
        .apx_ctl(apx_ctl2), .win_done(win_done2), .win_err(win_err2), .state(state2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs change at negedge; outputs are checked at the following negedge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic op(input logic [31:0] x, input logic [31:0] y);
        a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic op2(input logic [31:0] x, input logic [31:0] y);
        a2 = x; b2 = y; in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
    endtask

    task automatic window(input logic [31:0] x, input logic [31:0] y);
        for (int i = 0; i < 4; i++) op(x, y);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; force_acc = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        thr_hi = 16'd20; thr_lo = 16'd4;
        en2 = 1'b0; in_valid2 = 1'b0; a2 = '0; b2 = '0; thr_hi2 = 8'd20; thr_lo2 = 8'd4;
        step(); step();
        rst = 1'b0;

        // 1. Reset values held while disabled
        check("rst_state", 32'(state), 0);
        check("rst_apx", 32'(apx_ctl), 0);
        check("rst_done", 32'(win_done), 0);
        check("rst_err", 32'(win_err), 0);
        check("rst_state2", 32'(state2), 0);
        check("rst_err2", 32'(win_err2), 0);
        for (int i = 0; i < 10; i++) begin
            op(32'h0F, 32'h0F);
            check("idle_state", 32'(state), 0);
            check("idle_done", 32'(win_done), 0);
        end
        check("idle_apx", 32'(apx_ctl), 0);
        check("idle_err", 32'(win_err), 0);

        // 2. Low error window stays approximate
        en = 1'b1;
        step();
        check("en_state", 32'(state), 1);
        check("en_apx", 32'(apx_ctl), 1);
        for (int i = 0; i < 3; i++) op(32'h13, 32'h21);
        check("lo_early_done", 32'(win_done), 0);
        op(32'h13, 32'h21);
        check("lo_done", 32'(win_done), 1);
        check("lo_err", 32'(win_err), 16);
        check("lo_state", 32'(state), 1);
        check("lo_apx", 32'(apx_ctl), 1);
        step();
        check("lo_done_pulse", 32'(win_done), 0);

        // 3. High error with gaps between ops
        for (int i = 0; i < 3; i++) begin
            op(32'h0F, 32'h0F);
            step();
        end
        check("hi_gap_done", 32'(win_done), 0);
        check("hi_gap_state", 32'(state), 1);
        check("hi_gap_apx", 32'(apx_ctl), 1);
        op(32'h0F, 32'h0F);
        check("hi_done", 32'(win_done), 1);
        check("hi_err", 32'(win_err), 120);
        check("hi_state", 32'(state), 2);
        check("hi_apx", 32'(apx_ctl), 0);

        // 4. Recovery: good, bad, good, good
        window(32'h10, 32'h01);
        check("rec1_err", 32'(win_err), 4);
        check("rec1_state", 32'(state), 3);
        check("rec1_apx", 32'(apx_ctl), 0);
        window(32'h0F, 32'h0F);
        check("rec2_state", 32'(state), 2);
        check("rec2_apx", 32'(apx_ctl), 0);
        window(32'h10, 32'h01);
        check("rec3_state", 32'(state), 3);
        check("rec3_apx", 32'(apx_ctl), 0);
        window(32'h10, 32'h01);
        check("rec4_state", 32'(state), 1);
        check("rec4_apx", 32'(apx_ctl), 1);

        // 6. Abort mid-window, then force_acc override
        op(32'h10, 32'h01);
        op(32'h10, 32'h01);
        en = 1'b0;
        step();
        check("abort_state", 32'(state), 0);
        check("abort_apx", 32'(apx_ctl), 0);
        check("abort_err_held", 32'(win_err), 4);
        en = 1'b1;
        step();
        check("reen_state", 32'(state), 1);
        for (int i = 0; i < 3; i++) op(32'h13, 32'h21);
        check("reen_early_done", 32'(win_done), 0);
        op(32'h13, 32'h21);
        check("reen_done", 32'(win_done), 1);
        check("reen_err", 32'(win_err), 16);
        force_acc = 1'b1;
        step();
        check("force_apx", 32'(apx_ctl), 0);
        check("force_state", 32'(state), 1);
        force_acc = 1'b0;
        step();
        check("release_apx", 32'(apx_ctl), 1);

        // 5. Saturation on the narrow accumulator
        en2 = 1'b1;
        step();
        check("sat_en_state", 32'(state2), 1);
        for (int i = 0; i < 15; i++) op2(32'h0F, 32'h0F);
        check("sat_early_done", 32'(win_done2), 0);
        op2(32'h0F, 32'h0F);
        check("sat_done", 32'(win_done2), 1);
        check("sat_err", 32'(win_err2), 255);
        check("sat_state", 32'(state2), 2);
        check("sat_apx", 32'(apx_ctl2), 0);

        // Asynchronous reset mid-window
        op(32'h13, 32'h21);
        op(32'h13, 32'h21);
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_apx", 32'(apx_ctl), 0);
        check("arst_err", 32'(win_err), 0);
        check("arst_state2", 32'(state2), 0);
        step();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_int_add_apx_ctrl.md
Name: config_int_add_apx_ctrl

Overview:
Closed-loop controller that generates apx_ctl for the input-truncation configurable adder, which consumes that signal. It watches the same operand stream fed to the adder and computes the exact error that truncating the low HRDWIRED_BITWIDTH bits causes. It accumulates this error over fixed windows of operations. An FSM with hysteresis then enables or disables approximation at window boundaries.

Parameters:
DATA_PATH_BITWIDTH  32  operand width; must match the adder
HRDWIRED_BITWIDTH  4  truncated low bits; must match the adder; legal range 1..DATA_PATH_BITWIDTH-1
WINDOW  16  valid operations per evaluation window; must be >=2
ERR_ACC_BITWIDTH  16  width of the window error accumulator and of the thresholds
HOLD_WINDOWS  2  consecutive good windows required before approximation is re-enabled; must be >=1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  controller enable; 0 forces IDLE
force_acc  in  1  forces apx_ctl=0 without affecting the FSM or the accumulator
in_valid  in  1  a/b carry an operation this cycle
a  in  DATA_PATH_BITWIDTH  operand A, same value driven to the adder
b  in  DATA_PATH_BITWIDTH  operand B, same value driven to the adder
err_thresh_hi  in  ERR_ACC_BITWIDTH  window error above which approximation is disabled
err_thresh_lo  in  ERR_ACC_BITWIDTH  window error at or below which a window counts as good
apx_ctl  out  1  registered approximation enable, driven to the adder
win_done  out  1  one-cycle pulse on window close
win_err  out  ERR_ACC_BITWIDTH  saturated error of the last closed window
state  out  2  FSM state: IDLE=0, APX=1, ACC=2, RECOVER=3

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE, apx_ctl=0, win_done=0, win_err=0.
  - Accumulator, op counter and good-window counter cleared.
- Per-op error: e = a[H-1:0] + b[H-1:0] (H = HRDWIRED_BITWIDTH), computed at H+1 bits, zero-extended. e is exactly the exact sum minus the truncated sum.
- e is computed in every state except IDLE, including while accurate. This lets recovery be judged on hypothetical error.
- Accumulation: on in_valid, acc <= sat(acc + e), op_cnt <= op_cnt + 1. sat() clamps at 2^ERR_ACC_BITWIDTH - 1 and never wraps.
- Window close: the edge where in_valid=1 and op_cnt==WINDOW-1. On that edge:
  - win_err <= sat(acc + e) and win_done=1 for that cycle only.
  - acc <= 0 and op_cnt <= 0.
  - The FSM evaluates using E = sat(acc + e).
- Cycles with in_valid=0 hold acc and op_cnt. Windows count operations, not cycles.
- FSM transitions, evaluated only on window close unless noted:
  - IDLE: en=1 -> APX on the next edge, counters cleared. No window is evaluated in IDLE.
  - APX: E > err_thresh_hi -> ACC; otherwise stay.
  - ACC: E <= err_thresh_lo -> RECOVER with good_cnt=1, or directly APX if HOLD_WINDOWS==1; otherwise stay.
  - RECOVER: E <= err_thresh_lo -> good_cnt+1; when good_cnt reaches HOLD_WINDOWS -> APX and good_cnt=0. E > err_thresh_lo -> ACC and good_cnt=0.
  - E between lo and hi in APX stays APX (hysteresis).
- Any state: en=0 -> IDLE on the next edge; acc, op_cnt and good_cnt cleared; win_err held. en dominates a window close on the same edge, in which case win_done still pulses and win_err still updates.
- apx_ctl is a register: apx_ctl <= (next_state==APX) & ~force_acc & en.
  - apx_ctl changes on the same edge as state, which is one edge after the closing operation was presented.
  - Operations issued after that edge see the new mode.
- force_acc takes effect on the next edge. It does not stall the accumulator or the FSM.
- Threshold inputs are sampled only at window close. Changing them mid-window is legal.
- Asserting rst mid-window discards the partial window and returns to the reset values above.

Test Plan:
Common configuration: H=4, WINDOW=4, ERR_ACC_BITWIDTH=16, HOLD_WINDOWS=2, err_thresh_hi=20, err_thresh_lo=4.
1. Reset: rst=1 then 0 with en=0 -> apx_ctl=0, win_done=0, win_err=0, state=0, held over 10 cycles of in_valid=1.
2. Low error: en=1, 4 valid ops a=0x13, b=0x21 (e=4 each) -> win_done pulse, win_err=16, state stays APX=1, apx_ctl stays 1.
3. High error: 4 valid ops a=0x0F, b=0x0F (e=30 each), in_valid gapped every other cycle -> win_err=120, state=ACC=2. apx_ctl falls on the closing edge; gaps do not close the window early.
4. Recovery with hysteresis:
   - From ACC, windows of a=0x10, b=0x01 (e=1, E=4) in the sequence good, bad (E=120), good, good.
   - Required states: RECOVER, ACC, RECOVER, APX; apx_ctl=1 only after the final window.
5. Saturation: ERR_ACC_BITWIDTH=8, WINDOW=16, e=30 per op -> win_err=255, not 480 mod 256 (=224); state=ACC.
6. Abort and override:
   - After 2 ops, drop en for 1 cycle -> state=IDLE, apx_ctl=0. On re-enable, the next window closes only after 4 further ops.
   - force_acc=1 while in APX -> apx_ctl=0 next edge with state still 1; release -> apx_ctl=1 next edge.
